// File: rtl/rf_dump_reader.sv
// rf_dump_reader: walks the register file inspection port from FIRST_REG to
// LAST_REG and serializes each register as an optional index byte followed
// by four data bytes, MSB first, on a valid/ready byte stream.
// Ports: clk, rst (async, active-high); start/abort control;
//        reg_sel/reg_data inspection port;
//        out_valid/out_data/out_ready byte stream;
//        busy (not idle), done (one-cycle end-of-dump pulse).
module rf_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int INDEX_TAG = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [4:0] FIRST_SEL = FIRST_REG[4:0];
    localparam logic [4:0] LAST_SEL  = LAST_REG[4:0];
    // Without the index tag the shift register starts one byte further on.
    localparam logic [2:0] FIRST_BYTE = (INDEX_TAG != 0) ? 3'd0 : 3'd1;
    localparam logic [2:0] LAST_BYTE  = 3'd4;

    state_t      state_q, state_d;
    logic [4:0]  reg_sel_q, reg_sel_d;
    logic [39:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d   = state_q;
        reg_sel_d = reg_sel_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    reg_sel_d = FIRST_SEL;
                    state_d   = SEL;
                end
            end
            SEL: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (INDEX_TAG != 0) begin
                        shift_d = {3'b000, reg_sel_q, reg_data};
                    end else begin
                        shift_d = {reg_data, 8'h00};
                    end
                    cnt_d   = FIRST_BYTE;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Abort wins over a same-cycle handshake: byte not consumed.
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    shift_d = {shift_q[31:0], 8'h00};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == LAST_BYTE) begin
                        if (reg_sel_q == LAST_SEL) begin
                            state_d = DONE;
                        end else begin
                            reg_sel_d = reg_sel_q + 5'd1;
                            state_d   = SEL;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flag outputs are registered copies of the next state.
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            reg_sel_q   <= 5'd0;
            shift_q     <= 40'd0;
            cnt_q       <= 3'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_sel_q   <= reg_sel_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign reg_sel   = reg_sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = shift_q[39:32];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Testbench for rf_dump_reader: default instance plus an untagged
// two-register instance, checked against a byte-stream reference model.
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;

    logic        start2 = 1'b0;
    logic        abort2 = 1'b0;
    logic [4:0]  reg_sel2;
    logic [31:0] reg_data2;
    logic        out_valid2;
    logic [7:0]  out_data2;
    logic        out_ready2 = 1'b1;
    logic        busy2;
    logic        done2;

    logic [31:0] rf [32];

    int total = 0;
    int bad = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int done_cyc;
    int done_cnt;
    int stall_chg;
    int first_valid;
    logic busy_after;

    always #5 clk = ~clk;

    assign reg_data  = (reg_sel == 5'd0) ? 32'd0 : rf[reg_sel];
    assign reg_data2 = (reg_sel2 == 5'd0) ? 32'd0 : rf[reg_sel2];

    rf_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .reg_sel(reg_sel), .reg_data(reg_data),
        .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    rf_dump_reader #(
        .FIRST_REG(5), .LAST_REG(6), .INDEX_TAG(0)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .reg_sel(reg_sel2), .reg_data(reg_data2),
        .out_valid(out_valid2), .out_data(out_data2),
        .out_ready(out_ready2), .busy(busy2), .done(done2)
    );

    // Reference stream: per register, optional index then 4 bytes MSB first.
    task automatic build_exp(input int first, input int last, input int tag);
        logic [31:0] v;
        logic [7:0]  idx;
        exp_q.delete();
        for (int k = first; k <= last; k++) begin
            v = (k == 0) ? 32'd0 : rf[k];
            idx = 8'(k);
            if (tag != 0) exp_q.push_back(idx);
            exp_q.push_back(v[31:24]);
            exp_q.push_back(v[23:16]);
            exp_q.push_back(v[15:8]);
            exp_q.push_back(v[7:0]);
        end
    endtask

    function automatic int stream_diff();
        int n;
        n = 0;
        if (got.size() != exp_q.size()) n++;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic fill_linear();
        for (int k = 0; k < 32; k++) rf[k] = 32'h1000_0000 + 32'(k);
    endtask

    // mode 0: ready high; 1: ready 1,0,0 repeating; 2: random ready.
    task automatic run_dump(input int mode, input int restart_at,
                            input int budget);
        int c;
        logic stalled;
        logic [7:0] held;
        got.delete();
        done_cyc = -1;
        done_cnt = 0;
        stall_chg = 0;
        first_valid = -1;
        busy_after = 1'bx;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        stalled = 1'b0;
        held = 8'h00;
        while (c < budget) begin
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                busy_after = busy;
                break;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (out_valid && first_valid < 0) first_valid = c;
            if (stalled && (out_valid !== 1'b1 || out_data !== held))
                stall_chg++;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (c % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) got.push_back(out_data);
            stalled = out_valid && !out_ready;
            held = out_data;
            start = (c == restart_at);
            @(negedge clk);
            c++;
        end
        out_ready = 1'b1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({reg_sel, out_valid, out_data, busy, done} !== 16'd0) begin
            bad++;
            $display("FAIL reset_outputs got sel=%0d v=%b d=%h b=%b dn=%b want all 0",
                     reg_sel, out_valid, out_data, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_dump();
        fill_linear();
        build_exp(0, 31, 1);
        run_dump(0, -1, 400);
        total++;
        if (got.size() !== 160) begin
            bad++;
            $display("FAIL full_len got %0d want 160", got.size());
        end
        total++;
        if (stream_diff() != 0) begin
            bad++;
            $display("FAIL full_stream got %0d diffs want 0", stream_diff());
        end
        total++;
        if (got.size() > 9 && got[5] !== 8'h01) begin
            bad++;
            $display("FAIL full_idx1 got %h want 01", got[5]);
        end
        total++;
        if (first_valid != 1) begin
            bad++;
            $display("FAIL first_valid_lat got %0d want 1", first_valid);
        end
        total++;
        if (done_cyc != 192) begin
            bad++;
            $display("FAIL full_done_cyc got %0d want 192", done_cyc);
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL full_done_cnt got %0d want 1", done_cnt);
        end
        total++;
        if (busy_after !== 1'b0) begin
            bad++;
            $display("FAIL full_busy_after got %b want 0", busy_after);
        end
        total++;
        if (reg_sel !== 5'd31) begin
            bad++;
            $display("FAIL full_sel_hold got %0d want 31", reg_sel);
        end
    endtask

    task automatic test_backpressure();
        fill_linear();
        build_exp(0, 31, 1);
        run_dump(1, -1, 1200);
        total++;
        if (stream_diff() != 0) begin
            bad++;
            $display("FAIL bp_stream got %0d diffs want 0", stream_diff());
        end
        total++;
        if (stall_chg != 0) begin
            bad++;
            $display("FAIL bp_stall_hold got %0d changes want 0", stall_chg);
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL bp_done_cnt got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 32; k++) rf[k] = $urandom;
            build_exp(0, 31, 1);
            run_dump(2, -1, 2000);
            total++;
            if (stream_diff() != 0) begin
                bad++;
                $display("FAIL rand_stream got %0d diffs want 0", stream_diff());
            end
            total++;
            if (stall_chg != 0 || done_cnt != 1) begin
                bad++;
                $display("FAIL rand_ctrl got chg=%0d done=%0d want 0/1",
                         stall_chg, done_cnt);
            end
        end
    endtask

    task automatic test_back_to_back_start();
        fill_linear();
        build_exp(0, 31, 1);
        run_dump(0, 50, 400);
        total++;
        if (stream_diff() != 0) begin
            bad++;
            $display("FAIL restart_stream got %0d diffs want 0", stream_diff());
        end
        total++;
        if (done_cyc != 192 || done_cnt != 1) begin
            bad++;
            $display("FAIL restart_done got cyc=%0d cnt=%0d want 192/1",
                     done_cyc, done_cnt);
        end
    endtask

    task automatic test_abort();
        int acc;
        int dn;
        logic hit;
        fill_linear();
        acc = 0;
        dn = 0;
        hit = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (out_valid && acc == 12) begin
                out_ready = 1'b0;
                abort = 1'b1;
                hit = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                out_ready = 1'b1;
                break;
            end
            out_ready = 1'b1;
            if (out_valid) acc++;
            @(negedge clk);
        end
        total++;
        if (!hit || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_stop got hit=%b v=%b b=%b want 1/0/0",
                     hit, out_valid, busy);
        end
        total++;
        if (reg_sel !== 5'd2) begin
            bad++;
            $display("FAIL abort_sel got %0d want 2", reg_sel);
        end
        for (int c = 0; c < 6; c++) begin
            if (done || busy || out_valid) dn++;
            @(negedge clk);
        end
        total++;
        if (dn != 0) begin
            bad++;
            $display("FAIL abort_quiet got %0d active cycles want 0", dn);
        end
        build_exp(0, 31, 1);
        run_dump(0, -1, 400);
        total++;
        if (stream_diff() != 0 || done_cyc != 192) begin
            bad++;
            $display("FAIL abort_restart got diffs=%0d done=%0d want 0/192",
                     stream_diff(), done_cyc);
        end
    endtask

    task automatic test_idle_abort();
        int act;
        act = 0;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (busy || out_valid) act++;
        @(negedge clk);
        if (busy || out_valid || done) act++;
        abort = 1'b0;
        @(negedge clk);
        if (busy || out_valid || done) act++;
        total++;
        if (act != 0) begin
            bad++;
            $display("FAIL idle_abort got %0d active samples want 0", act);
        end
    endtask

    task automatic test_async_rst();
        int act;
        act = 0;
        fill_linear();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if ({reg_sel, out_valid, out_data, busy, done} !== 16'd0) begin
            bad++;
            $display("FAIL async_rst got sel=%0d v=%b d=%h b=%b dn=%b want all 0",
                     reg_sel, out_valid, out_data, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid || busy || done) act++;
        end
        total++;
        if (act != 0) begin
            bad++;
            $display("FAIL post_rst_idle got %0d active cycles want 0", act);
        end
    endtask

    task automatic test_tag0(input logic [31:0] v5, input logic [31:0] v6);
        int dc;
        rf[5] = v5;
        rf[6] = v6;
        build_exp(5, 6, 0);
        got.delete();
        dc = -1;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done2 && dc < 0) dc = c;
            if (out_valid2 && out_ready2) got.push_back(out_data2);
            @(negedge clk);
        end
        total++;
        if (stream_diff() != 0) begin
            bad++;
            $display("FAIL tag0_stream got %0d diffs want 0", stream_diff());
        end
        total++;
        if (dc != 10) begin
            bad++;
            $display("FAIL tag0_done_cyc got %0d want 10", dc);
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = 32'd0;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_back_to_back_start();
        test_abort();
        test_idle_abort();
        test_random();
        test_tag0(32'hDEAD_BEEF, 32'h0123_4567);
        total++;
        if (got.size() > 0 && got[0] !== 8'hDE) begin
            bad++;
            $display("FAIL tag0_first got %h want de", got[0]);
        end
        test_tag0($urandom, $urandom);
        test_async_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
